// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory interface.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef logic [3:0] be_t;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

endpackage

// File: rtl/dmem_if_load_align.sv
// Load lane selection and sign/zero extension of a raw memory word.
// Latency: purely combinational. Backpressure: none.
// Unknown func3 codes pass the word through unchanged.
module load_align
    import dmem_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  offset,
    input  logic [2:0]  func3,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (offset)
            2'd0:    byte_lane = raw[7:0];
            2'd1:    byte_lane = raw[15:8];
            2'd2:    byte_lane = raw[23:16];
            default: byte_lane = raw[31:24];
        endcase
        half_lane = offset[1] ? raw[31:16] : raw[15:0];
    end

    always_comb begin
        case (func3)
            SZ_B:    result = {{24{byte_lane[7]}}, byte_lane};
            SZ_BU:   result = {24'd0, byte_lane};
            SZ_H:    result = {{16{half_lane[15]}}, half_lane};
            SZ_HU:   result = {16'd0, half_lane};
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/dmem_if.sv
// Data-memory interface: one load/store per instruction onto a req/gnt/rvalid port; optional DMEM_MISALIGN_TRAP_EN.
// Latency: zero-wait memory gives 2 stall cycles per load, 1 per store; each missing gnt/rvalid adds one.
// Backpressure: memStall holds the pipeline until DONE; dmem_req and payload stay stable until dmem_gnt.
module dmem_if
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        loadReq,
    input  logic        storeReq,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        memStall,
    output logic [31:0] rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
`ifdef DMEM_MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    input  logic [31:0] dmem_rdata
);

    state_t      state, next_state;
    logic        req_present;
    logic        is_load;
    logic        is_store;
    logic        misal;
    be_t         be;
    logic [31:0] wdata_rep;
    logic [31:0] load_data;

    // A simultaneous load and store resolves to the load.
    assign req_present = loadReq | storeReq;
    assign is_load     = loadReq;
    assign is_store    = storeReq & ~loadReq;

    always_comb begin
        case (func3)
            SZ_B, SZ_BU: begin
                be        = be_t'(4'b0001 << addr[1:0]);
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_H, SZ_HU: begin
                be        = be_t'(4'b0011 << {addr[1], 1'b0});
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    always_comb begin
        case (func3)
            SZ_H, SZ_HU: misal = addr[0];
            SZ_B, SZ_BU: misal = 1'b0;
            default:     misal = |addr[1:0];
        endcase
    end
`else
    assign misal = 1'b0;
`endif

    load_align u_load_align (
        .raw    (dmem_rdata),
        .offset (addr[1:0]),
        .func3  (func3),
        .result (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        memStall   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = 32'd0;
        dmem_be    = 4'd0;
        dmem_wdata = 32'd0;
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (req_present) begin
                    memStall = 1'b1;
                    if (misal) begin
`ifdef DMEM_MISALIGN_TRAP_EN
                        misalign = 1'b1;
`endif
                        next_state = DONE;
                    end else begin
                        dmem_req   = 1'b1;
                        dmem_we    = is_store;
                        dmem_addr  = {addr[31:2], 2'b00};
                        dmem_be    = be;
                        dmem_wdata = wdata_rep;
                        if (dmem_gnt) begin
                            next_state = is_load ? WAIT : DONE;
                        end
                    end
                end
            end
            WAIT: begin
                memStall = 1'b1;
                if (dmem_rvalid) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 32'd0;
        end else if (state == WAIT && dmem_rvalid) begin
            rdata <= load_data;
        end else if (state == IDLE && is_load && misal) begin
            rdata <= 32'd0;
        end
    end

endmodule

// File: tb/tb_dmem_if.sv
// Directed bench for dmem_if: handshake timing, byte enables, load extension, reset abort.
module tb_dmem_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        loadReq, storeReq;
    logic [2:0]  func3;
    logic [31:0] addr, wdata;
    logic        memStall;
    logic [31:0] rdata;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // access results gathered by run_access
    int          stalls, reqs, mis_cnt;
    logic        done, unstable;
    logic [31:0] p_req, p_we, p_addr, p_be, p_wd;

    dmem_if dut (
        .clk         (clk),
        .rst         (rst),
        .loadReq     (loadReq),
        .storeReq    (storeReq),
        .func3       (func3),
        .addr        (addr),
        .wdata       (wdata),
        .memStall    (memStall),
        .rdata       (rdata),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
`ifdef DMEM_MISALIGN_TRAP_EN
        .misalign    (misalign),
`endif
        .dmem_rdata  (dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one access from posedge+1; gnt after gdly cycles, rvalid rdly cycles into WAIT.
    // Returns at posedge+1 of the cycle after DONE with requests dropped.
    task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mw,
                              input int gdly, input int rdly);
        logic granted;
        int   rc;
        granted  = 1'b0;
        rc       = 0;
        stalls   = 0;
        reqs     = 0;
        mis_cnt  = 0;
        done     = 1'b0;
        unstable = 1'b0;
        loadReq  = ld;
        storeReq = st;
        func3    = f3;
        addr     = a;
        wdata    = wd;
        dmem_rdata = mw;
        for (int c = 0; c < 40 && !done; c++) begin
            dmem_gnt    = (c >= gdly) && !granted;
            dmem_rvalid = granted && ld && (rc >= rdly);
            @(negedge clk);
            if (c == 0) begin
                p_req  = 32'(dmem_req);
                p_we   = 32'(dmem_we);
                p_addr = dmem_addr;
                p_be   = {28'd0, dmem_be};
                p_wd   = dmem_wdata;
            end else if (!granted) begin
                if (32'(dmem_req) != p_req || dmem_addr != p_addr ||
                    {28'd0, dmem_be} != p_be || dmem_wdata != p_wd || 32'(dmem_we) != p_we)
                    unstable = 1'b1;
            end
`ifdef DMEM_MISALIGN_TRAP_EN
            if (misalign) mis_cnt++;
`endif
            if (dmem_req) reqs++;
            if (memStall) stalls++;
            else          done = 1'b1;
            @(posedge clk);
            #1;
            if (granted) rc++;
            if (dmem_gnt) granted = 1'b1;
        end
        loadReq     = 1'b0;
        storeReq    = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        loadReq = 1'b0; storeReq = 1'b0; func3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        #12;
        check("rst_req",   32'(dmem_req), 32'd0);
        check("rst_we",    32'(dmem_we), 32'd0);
        check("rst_be",    {28'd0, dmem_be}, 32'd0);
        check("rst_addr",  dmem_addr, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("idle_stall", 32'(memStall), 32'd0);
        @(posedge clk);
        #1;

        // lb at 0x103, top byte 0x80 sign-extends
        run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF_1234, 0, 0);
        check("lb_done",  32'(done), 32'd1);
        check("lb_addr",  p_addr, 32'h100);
        check("lb_be",    p_be, 32'h8);
        check("lb_we",    p_we, 32'd0);
        check("lb_stall", 32'(stalls), 32'd2);
        check("lb_rdata", rdata, 32'hFFFF_FF80);

        run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF_1234, 0, 0);
        check("lbu_rdata", rdata, 32'h0000_0080);

        // sh at 0x202
        run_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 32'd0, 0, 0);
        check("sh_we",    p_we, 32'd1);
        check("sh_addr",  p_addr, 32'h200);
        check("sh_be",    p_be, 32'hC);
        check("sh_wdata", p_wd, 32'hABCD_ABCD);
        check("sh_stall", 32'(stalls), 32'd1);
        check("sh_rdata_hold", rdata, 32'h0000_0080);

        // lw, gnt withheld 3 cycles, rvalid 2 cycles after gnt
        run_access(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 32'hDEAD_BEEF, 3, 1);
        check("lw_wait_stall",  32'(stalls), 32'd6);
        check("lw_wait_reqs",   32'(reqs), 32'd4);
        check("lw_wait_stable", 32'(unstable), 32'd0);
        check("lw_wait_rdata",  rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        check("lw_one_done", 32'(memStall), 32'd0);
        @(posedge clk);
        #1;

        // back-to-back sw then lw with both requests high
        run_access(1'b0, 1'b1, 3'b010, 32'h404, 32'h1122_3344, 32'd0, 0, 0);
        check("sw_be",    p_be, 32'hF);
        check("sw_wdata", p_wd, 32'h1122_3344);
        check("sw_stall", 32'(stalls), 32'd1);
        run_access(1'b1, 1'b1, 3'b010, 32'h404, 32'hFFFF_FFFF, 32'h5566_7788, 0, 0);
        check("b2b_req",   p_req, 32'd1);
        check("both_we",   p_we, 32'd0);
        check("both_rdata", rdata, 32'h5566_7788);

        // halfword and byte lane selection
        run_access(1'b1, 1'b0, 3'b001, 32'h506, 32'd0, 32'h8001_7FFF, 0, 0);
        check("lh_hi_rdata", rdata, 32'hFFFF_8001);
        run_access(1'b1, 1'b0, 3'b101, 32'h504, 32'd0, 32'h8001_F00D, 0, 0);
        check("lhu_lo_rdata", rdata, 32'h0000_F00D);
        run_access(1'b1, 1'b0, 3'b000, 32'h101, 32'd0, 32'h0000_7F00, 0, 0);
        check("lb_pos_rdata", rdata, 32'h0000_007F);
        run_access(1'b0, 1'b1, 3'b000, 32'h603, 32'h0000_00A5, 32'd0, 0, 0);
        check("sb_be",    p_be, 32'h8);
        check("sb_wdata", p_wd, 32'hA5A5_A5A5);

        // misaligned lw at 0x101
        run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 32'h1234_5678, 0, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("mis_req",   p_req, 32'd0);
        check("mis_pulse", 32'(mis_cnt), 32'd1);
        check("mis_stall", 32'(stalls), 32'd1);
        check("mis_rdata", rdata, 32'd0);
`else
        check("mis_addr",  p_addr, 32'h100);
        check("mis_be",    p_be, 32'hF);
        check("mis_rdata", rdata, 32'h1234_5678);
`endif

        // reset while in WAIT, then a late rvalid
        loadReq = 1'b1; func3 = 3'b010; addr = 32'h700; dmem_gnt = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        @(posedge clk);
        #1;
        dmem_gnt = 1'b0;
        check("rst_wait_stall", 32'(memStall), 32'd1);
        rst = 1'b1;
        loadReq = 1'b0;
        #1;
        check("rst_mid_stall", 32'(memStall), 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b1;
        @(negedge clk);
        check("late_rv_stall", 32'(memStall), 32'd0);
        check("late_rv_req",   32'(dmem_req), 32'd0);
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        check("late_rv_rdata", rdata, 32'd0);
        @(posedge clk);
        #1;
        run_access(1'b1, 1'b0, 3'b010, 32'h800, 32'd0, 32'h0BAD_F00D, 0, 0);
        check("post_rst_stall", 32'(stalls), 32'd2);
        check("post_rst_rdata", rdata, 32'h0BAD_F00D);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
